ext_bus_sequencer: RTL and testbench

- Upstream neighbour of the core data mux. Runs one external memory access (M-cycle) per core request as a 4-state T-cycle sequence.
- Drives the external address and strobes, and the write data plus output enable onto the external data pins.
- Samples read data back and hands it to the core as a one-cycle response.
- Has a one-entry pending buffer so back-to-back accesses run without idle gaps, and honours an external wait line and the bus-disable test input.

---
 rtl/ext_bus_sequencer_if.sv | 64 ++++++
 rtl/ext_bus_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_ext_bus_sequencer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/ext_bus_sequencer_if.sv
// Core request/response and external memory bus signals of the external bus sequencer.
// The slave modport is the sequencer's view; the master modport is the core/board view.
interface ext_bus_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_timeout;
  logic [15:0] A;
  logic [7:0]  D_out;
  logic        D_oe;
  logic [7:0]  D_in;
  logic        nRD;
  logic        nWR;
  logic        nCS;
  logic        bus_wait;
  logic        Test1;
  logic        busy;

  modport slave (
    input  req_valid,
    input  req_write,
    input  req_addr,
    input  req_wdata,
    input  D_in,
    input  bus_wait,
    input  Test1,
    output req_ready,
    output rsp_valid,
    output rsp_rdata,
    output rsp_timeout,
    output A,
    output D_out,
    output D_oe,
    output nRD,
    output nWR,
    output nCS,
    output busy
  );

  modport master (
    output req_valid,
    output req_write,
    output req_addr,
    output req_wdata,
    output D_in,
    output bus_wait,
    output Test1,
    input  req_ready,
    input  rsp_valid,
    input  rsp_rdata,
    input  rsp_timeout,
    input  A,
    input  D_out,
    input  D_oe,
    input  nRD,
    input  nWR,
    input  nCS,
    input  busy
  );
endinterface

// File: rtl/ext_bus_sequencer.sv
// Runs one external memory M-cycle (T1..T4) per core request, with a one-entry pending
// buffer for gapless back-to-back accesses, bus_wait stretching of T3 and a bus-disable input.
module ext_bus_sequencer #(
  parameter int unsigned WAIT_MAX = 15,
  parameter logic [7:0]  OPEN_BUS = 8'hFF
) (
  input logic                CLK,
  input logic                RESET,
  ext_bus_sequencer_if.slave bus
);

  localparam logic [7:0]  WAIT_LIMIT = 8'(WAIT_MAX);
  localparam logic [15:0] EXT_END    = 16'hFE00;
  localparam logic [15:0] CS_BASE    = 16'hA000;

  typedef enum logic [2:0] {
    StIdle,
    StT1,
    StT2,
    StT3,
    StT4
  } state_e;

  state_e      r_state;
  state_e      w_state_next;

  logic        r_pend_valid;
  logic        r_pend_write;
  logic [15:0] r_pend_addr;
  logic [7:0]  r_pend_wdata;

  logic        r_write;
  logic        r_ext;
  logic [7:0]  r_wait_cnt;

  logic [15:0] r_a;
  logic [7:0]  r_d_out;
  logic        r_d_oe;
  logic        r_nrd;
  logic        r_nwr;
  logic        r_ncs;
  logic        r_rsp_valid;
  logic [7:0]  r_rsp_rdata;
  logic        r_rsp_timeout;
  logic        r_busy;

  logic        w_accept;
  logic        w_start;
  logic        w_from_pend;
  logic        w_to_pend;
  logic        w_wait_inc;
  logic        w_timeout;
  logic        w_t3_done;
  logic        w_sel_write;
  logic [15:0] w_sel_addr;
  logic [7:0]  w_sel_wdata;
  logic        w_sel_ext;
  logic        w_sel_cs;

  // Ready depends only on the buffer, so a T4 drain and a refill can share one edge.
  assign w_accept = bus.req_valid & ~r_pend_valid;

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_from_pend  = 1'b0;
    w_wait_inc   = 1'b0;
    w_timeout    = 1'b0;
    w_t3_done    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_state_next = StT1;
          w_start      = 1'b1;
        end
      end
      StT1: w_state_next = StT2;
      StT2: w_state_next = StT3;
      StT3: begin
        if (r_ext && bus.bus_wait && (r_wait_cnt != WAIT_LIMIT)) begin
          w_wait_inc = 1'b1;
        end else begin
          w_state_next = StT4;
          w_t3_done    = 1'b1;
          w_timeout    = r_ext & bus.bus_wait;
        end
      end
      StT4: begin
        if (r_pend_valid) begin
          w_state_next = StT1;
          w_start      = 1'b1;
          w_from_pend  = 1'b1;
        end else if (w_accept) begin
          w_state_next = StT1;
          w_start      = 1'b1;
        end else begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // An accepted request that does not start T1 directly is parked in the buffer.
  assign w_to_pend = w_accept & ~(w_start & ~w_from_pend);

  always_comb begin
    w_sel_write = bus.req_write;
    w_sel_addr  = bus.req_addr;
    w_sel_wdata = bus.req_wdata;
    if (w_from_pend) begin
      w_sel_write = r_pend_write;
      w_sel_addr  = r_pend_addr;
      w_sel_wdata = r_pend_wdata;
    end
  end

  assign w_sel_ext = (w_sel_addr < EXT_END) & ~bus.Test1;
  assign w_sel_cs  = w_sel_ext & (w_sel_addr >= CS_BASE);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= StIdle;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next != StIdle);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_pend_valid <= 1'b0;
      r_pend_write <= 1'b0;
      r_pend_addr  <= 16'h0000;
      r_pend_wdata <= 8'h00;
    end else begin
      if (w_from_pend) begin
        r_pend_valid <= 1'b0;
      end
      if (w_to_pend) begin
        r_pend_valid <= 1'b1;
        r_pend_write <= bus.req_write;
        r_pend_addr  <= bus.req_addr;
        r_pend_wdata <= bus.req_wdata;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_write    <= 1'b0;
      r_ext      <= 1'b0;
      r_wait_cnt <= 8'h00;
    end else begin
      if (w_start) begin
        r_write    <= w_sel_write;
        r_ext      <= w_sel_ext;
        r_wait_cnt <= 8'h00;
      end else if (w_wait_inc) begin
        r_wait_cnt <= r_wait_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_a     <= 16'h0000;
      r_d_out <= 8'h00;
      r_d_oe  <= 1'b0;
      r_nrd   <= 1'b1;
      r_nwr   <= 1'b1;
      r_ncs   <= 1'b1;
    end else begin
      if (w_start) begin
        r_a    <= w_sel_addr;
        r_ncs  <= ~w_sel_cs;
        r_d_oe <= 1'b0;
        r_nrd  <= 1'b1;
        r_nwr  <= 1'b1;
        if (w_sel_write) begin
          r_d_out <= w_sel_wdata;
        end
      end else if (r_state == StT1) begin
        r_nrd  <= ~(r_ext & ~r_write);
        r_nwr  <= ~(r_ext & r_write);
        r_d_oe <= r_ext & r_write;
      end else if (w_t3_done) begin
        r_nrd <= 1'b1;
        r_nwr <= 1'b1;
      end else if ((r_state == StT4) && (w_state_next == StIdle)) begin
        r_ncs  <= 1'b1;
        r_d_oe <= 1'b0;
      end
    end
  end

  // Read data is captured on the edge that leaves the last T3 cycle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= 8'h00;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_rsp_valid   <= w_t3_done;
      r_rsp_timeout <= w_t3_done & w_timeout;
      if (w_t3_done && !r_write) begin
        r_rsp_rdata <= r_ext ? bus.D_in : OPEN_BUS;
      end
    end
  end

  assign bus.req_ready   = ~r_pend_valid;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_rdata   = r_rsp_rdata;
  assign bus.rsp_timeout = r_rsp_timeout;
  assign bus.A           = r_a;
  assign bus.D_out       = r_d_out;
  assign bus.D_oe        = r_d_oe;
  assign bus.nRD         = r_nrd;
  assign bus.nWR         = r_nwr;
  assign bus.nCS         = r_ncs;
  assign bus.busy        = r_busy;

endmodule

// File: tb/tb_ext_bus_sequencer.sv
// Directed bench for ext_bus_sequencer: a table of single accesses from IDLE plus
// hand-written back-to-back and reset-abort sequences.
module tb_ext_bus_sequencer;

  logic CLK = 1'b0;
  logic RESET;

  ext_bus_sequencer_if bus ();

  ext_bus_sequencer #(
    .WAIT_MAX(15),
    .OPEN_BUS(8'hFF)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  din;
    logic        test1;
    int          nwait;
    logic [7:0]  e_rdata;
    logic        e_to;
    int          e_rsp;
    int          e_nrd;
    int          e_nwr;
    int          e_ncs;
    int          e_doe;
  } vec_t;

  vec_t vecs [10];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int rsp_cnt = 0, rsp_at = 0, nrd = 0, nwr = 0, ncs = 0, doe = 0;
    int dout_bad = 0, a_bad = 0, busy_cnt = 0;
    logic [7:0] rdata = 8'h00;
    logic       to = 1'b0;
    @(negedge CLK);
    bus.D_in      = v.din;
    bus.Test1     = v.test1;
    bus.bus_wait  = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_write = v.wr;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    @(posedge CLK);
    #1 bus.req_valid = 1'b0;
    for (int c = 1; c <= 25; c++) begin
      @(negedge CLK);
      bus.bus_wait = (c >= 3) && (c < 3 + v.nwait);
      if (!bus.nRD) nrd++;
      if (!bus.nWR) nwr++;
      if (!bus.nCS) ncs++;
      if (bus.D_oe) begin
        doe++;
        if (bus.D_out !== v.wdata) dout_bad++;
      end
      if (bus.busy) begin
        busy_cnt++;
        if (bus.A !== v.addr) a_bad++;
      end
      if (bus.rsp_valid) begin
        rsp_cnt++;
        rsp_at = c;
        rdata  = bus.rsp_rdata;
        to     = bus.rsp_timeout;
      end
    end
    bus.bus_wait = 1'b0;
    bus.Test1    = 1'b0;
    check($sformatf("v%0d rsp_count", idx), rsp_cnt, 1);
    check($sformatf("v%0d rsp_cycle", idx), rsp_at, v.e_rsp);
    check($sformatf("v%0d rsp_rdata", idx), rdata, v.e_rdata);
    check($sformatf("v%0d rsp_timeout", idx), to, v.e_to);
    check($sformatf("v%0d nRD_low", idx), nrd, v.e_nrd);
    check($sformatf("v%0d nWR_low", idx), nwr, v.e_nwr);
    check($sformatf("v%0d nCS_low", idx), ncs, v.e_ncs);
    check($sformatf("v%0d D_oe_high", idx), doe, v.e_doe);
    check($sformatf("v%0d D_out_bad", idx), dout_bad, 0);
    check($sformatf("v%0d busy_cycles", idx), busy_cnt, v.e_rsp);
    check($sformatf("v%0d A_bad", idx), a_bad, 0);
    check($sformatf("v%0d A_idle_hold", idx), bus.A, v.addr);
  endtask

  initial begin
    logic rv [1:12];
    logic rdy [1:12];
    logic bsy [1:12];
    logic [15:0] a5;
    logic [7:0]  rd4;
    logic [7:0]  rd8;
    int nwr_cnt;
    int cnt;

    //              wr    addr      wdata  din    t1    nw   rdata  to    rsp nrd nwr ncs doe
    vecs[0] = '{1'b0, 16'hC123, 8'h00, 8'h5A, 1'b0, 0,   8'h5A, 1'b0, 4,  2,  0,  4,  0};
    vecs[1] = '{1'b1, 16'h8000, 8'h3C, 8'h00, 1'b0, 0,   8'h5A, 1'b0, 4,  0,  2,  0,  3};
    vecs[2] = '{1'b0, 16'hA000, 8'h00, 8'h77, 1'b0, 3,   8'h77, 1'b0, 7,  5,  0,  7,  0};
    vecs[3] = '{1'b0, 16'h1234, 8'h00, 8'h99, 1'b0, 255, 8'h99, 1'b1, 19, 17, 0,  0,  0};
    vecs[4] = '{1'b0, 16'h4000, 8'h00, 8'h12, 1'b1, 0,   8'hFF, 1'b0, 4,  0,  0,  0,  0};
    vecs[5] = '{1'b0, 16'hFF80, 8'h00, 8'h34, 1'b0, 2,   8'hFF, 1'b0, 4,  0,  0,  0,  0};
    vecs[6] = '{1'b1, 16'hFDFF, 8'hA5, 8'h00, 1'b0, 1,   8'hFF, 1'b0, 5,  0,  3,  5,  4};
    vecs[7] = '{1'b1, 16'hFE00, 8'h11, 8'h00, 1'b0, 0,   8'hFF, 1'b0, 4,  0,  0,  0,  0};
    vecs[8] = '{1'b0, 16'h9FFF, 8'h00, 8'hC3, 1'b0, 0,   8'hC3, 1'b0, 4,  2,  0,  0,  0};
    vecs[9] = '{1'b1, 16'hA000, 8'h66, 8'h00, 1'b1, 0,   8'hC3, 1'b0, 4,  0,  0,  0,  0};

    RESET         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = 16'h0000;
    bus.req_wdata = 8'h00;
    bus.D_in      = 8'h00;
    bus.bus_wait  = 1'b0;
    bus.Test1     = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    check("rst A", bus.A, 16'h0000);
    check("rst D_out", bus.D_out, 8'h00);
    check("rst D_oe", bus.D_oe, 1'b0);
    check("rst strobes", {bus.nRD, bus.nWR, bus.nCS}, 3'b111);
    check("rst rsp", {bus.rsp_valid, bus.rsp_rdata, bus.rsp_timeout}, 10'h000);
    check("rst busy", bus.busy, 1'b0);
    check("rst req_ready", bus.req_ready, 1'b1);

    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i], i);
    end

    // Back-to-back: read 0100 at edge k, write 0200 at edge k+1 goes to the buffer.
    @(negedge CLK);
    bus.D_in      = 8'h6D;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 16'h0100;
    @(posedge CLK);
    #1;
    bus.req_write = 1'b1;
    bus.req_addr  = 16'h0200;
    bus.req_wdata = 8'h5E;
    @(posedge CLK);
    #1 bus.req_valid = 1'b0;
    nwr_cnt = 0;
    a5 = 16'h0000;
    rd4 = 8'h00;
    rd8 = 8'h00;
    for (int c = 2; c <= 12; c++) begin
      @(negedge CLK);
      rv[c]  = bus.rsp_valid;
      rdy[c] = bus.req_ready;
      bsy[c] = bus.busy;
      if (!bus.nWR) nwr_cnt++;
      if (c == 5) a5 = bus.A;
      if (c == 4) rd4 = bus.rsp_rdata;
      if (c == 8) rd8 = bus.rsp_rdata;
    end
    check("b2b ready k+1", rdy[2], 1'b0);
    check("b2b ready T4", rdy[4], 1'b0);
    check("b2b ready drained", rdy[5], 1'b1);
    check("b2b rsp pulses", {rv[3], rv[4], rv[5], rv[7], rv[8], rv[9]}, 6'b010010);
    check("b2b busy no gap", {bsy[2], bsy[3], bsy[4], bsy[5], bsy[6], bsy[7], bsy[8], bsy[9]},
          8'b11111110);
    check("b2b second A", a5, 16'h0200);
    check("b2b rdata", rd4, 8'h6D);
    check("b2b write holds rdata", rd8, 8'h6D);
    check("b2b nWR low", nwr_cnt, 2);

    // Reset in T2 of a write with a buffered read: abort, no response, buffer dropped.
    @(negedge CLK);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 16'h8100;
    bus.req_wdata = 8'h42;
    @(posedge CLK);
    #1;
    bus.req_write = 1'b0;
    bus.req_addr  = 16'h0300;
    @(posedge CLK);
    #1 bus.req_valid = 1'b0;
    @(negedge CLK);
    check("rstmid T2 nWR", bus.nWR, 1'b0);
    check("rstmid T2 req_ready", bus.req_ready, 1'b0);
    RESET = 1'b1;
    @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    check("rstmid busy", bus.busy, 1'b0);
    check("rstmid nWR", bus.nWR, 1'b1);
    check("rstmid D_oe", bus.D_oe, 1'b0);
    check("rstmid rsp_valid", bus.rsp_valid, 1'b0);
    check("rstmid req_ready", bus.req_ready, 1'b1);
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge CLK);
      if (bus.rsp_valid || bus.busy) cnt++;
    end
    check("rstmid pending dropped", cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
